// File: rtl/mte_stream_engine.sv
// MAC-then-Encrypt frame engine: buffers MSG_WORDS words, computes a chained keyed MAC, emits ciphertext+MAC or verified plaintext.
// Latency: first output word is valid 1 cycle after the last input accept (encrypt), 2 cycles (decrypt, via CHECK).
// Backpressure: in_ready drops during CHECK/EMIT; output words hold until out_ready. Optional MTE_ERR_CNT_EN adds err_count.
module mte_stream_engine #(
    parameter int N         = 8,
    parameter int MSG_WORDS = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] key,
    input  logic         sel,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         valid_key
`ifdef MTE_ERR_CNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    // Index spans plaintext words plus the trailing MAC word slot.
    localparam int IW = $clog2(MSG_WORDS + 2);
    localparam int BW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST_PT = IW'(MSG_WORDS - 1);
    localparam logic [IW-1:0] IDX_MAC     = IW'(MSG_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   key_q, key_d;
    logic           sel_q, sel_d;
    logic [N-1:0]   mac_q, mac_d;
    logic [N-1:0]   rx_mac_q, rx_mac_d;
    logic           match_q, match_d;
    logic           valid_key_q, valid_key_d;
    logic [N-1:0]   data_buf_q [MSG_WORDS];
    logic [N-1:0]   data_buf_d [MSG_WORDS];
`ifdef MTE_ERR_CNT_EN
    logic [15:0]    err_cnt_q, err_cnt_d;
`endif

    logic [BW-1:0]  bidx;
    logic [N-1:0]   first_pt;
    logic [N-1:0]   load_pt;

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1]};
    endfunction

    assign bidx      = idx_q[BW-1:0];
    // First word uses the live key/sel; later words use the latched copies.
    assign first_pt  = sel ? in_data : (in_data ^ key);
    assign load_pt   = sel_q ? in_data : (in_data ^ key_q);
    assign valid_key = valid_key_q;
`ifdef MTE_ERR_CNT_EN
    assign err_count = err_cnt_q;
`endif

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        key_d       = key_q;
        sel_d       = sel_q;
        mac_d       = mac_q;
        rx_mac_d    = rx_mac_q;
        match_d     = match_q;
        valid_key_d = valid_key_q;
        data_buf_d  = data_buf_q;
`ifdef MTE_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    key_d         = key;
                    sel_d         = sel;
                    valid_key_d   = 1'b0;
                    data_buf_d[0] = first_pt;
                    mac_d         = rotl1(key ^ first_pt);
                    if (sel && (MSG_WORDS == 1)) begin
                        idx_d       = '0;
                        valid_key_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx_q != IDX_MAC) begin
                        data_buf_d[bidx] = load_pt;
                        mac_d            = rotl1(mac_q ^ load_pt);
                        idx_d            = idx_q + 1'b1;
                        if (sel_q && (idx_q == IDX_LAST_PT)) begin
                            idx_d       = '0;
                            valid_key_d = 1'b1;
                            state_d     = EMIT;
                        end
                    end else begin
                        // Decrypt only: the word after the payload is the MAC.
                        rx_mac_d = load_pt;
                        idx_d    = '0;
                        state_d  = CHECK;
                    end
                end
            end
            CHECK: begin
                match_d     = (mac_q == rx_mac_q);
                valid_key_d = match_d;
`ifdef MTE_ERR_CNT_EN
                if (!match_d && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
`endif
                idx_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (sel_q) begin
                    out_data = (idx_q == IDX_MAC) ? (mac_q ^ key_q) : (data_buf_q[bidx] ^ key_q);
                    out_last = (idx_q == IDX_MAC);
                end else begin
                    out_data = match_q ? data_buf_q[bidx] : '0;
                    out_last = (idx_q == IDX_LAST_PT);
                end
                if (out_ready) begin
                    if (out_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            key_q       <= '0;
            sel_q       <= 1'b0;
            mac_q       <= '0;
            rx_mac_q    <= '0;
            match_q     <= 1'b0;
            valid_key_q <= 1'b0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                data_buf_q[i] <= '0;
            end
`ifdef MTE_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            sel_q       <= sel_d;
            mac_q       <= mac_d;
            rx_mac_q    <= rx_mac_d;
            match_q     <= match_d;
            valid_key_q <= valid_key_d;
            for (int i = 0; i < MSG_WORDS; i++) begin
                data_buf_q[i] <= data_buf_d[i];
            end
`ifdef MTE_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mte_stream_engine.sv
// Scoreboard bench for mte_stream_engine (N=8, MSG_WORDS=4).
// Stimulus pushes expected output words; a negedge monitor pops and compares on each accepted word.
// A stall driver holds out_ready low 3 cycles per word when enabled.
module tb_mte_stream_engine;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] key = 8'h00;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       valid_key;
`ifdef MTE_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    logic       stall_mode = 1'b0;
    int         stall_cnt  = 0;
    logic       held_vld   = 1'b0;
    logic [7:0] held_dat   = 8'h00;

    mte_stream_engine #(.N(8), .MSG_WORDS(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .key       (key),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .valid_key (valid_key)
`ifdef MTE_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        exp_t e;
        e.dat  = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Present one word and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] d, input logic [7:0] k, input logic s);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        key      = k;
        sel      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never seen for word %h", d);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then confirm the engine is idle again.
    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: %0d words still expected, 0 required", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
        check({name, "_idle_in_ready"}, {15'd0, in_ready}, 16'd1);
        check({name, "_idle_out_valid"}, {15'd0, out_valid}, 16'd0);
    endtask

    // Downstream ready: always 1, or 3 low cycles then 1 for each presented word.
    always @(posedge clock) begin
        #1;
        if (!stall_mode) begin
            out_ready = 1'b1;
            stall_cnt = 0;
        end else if (out_valid) begin
            if (stall_cnt == 3) begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end else begin
                out_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    // Output monitor: compare accepted words with the scoreboard, check stability and in_ready in EMIT.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid) begin
            check("emit_in_ready_low", {15'd0, in_ready}, 16'd0);
            if (held_vld) begin
                check("stall_data_stable", {8'd0, out_data}, {8'd0, held_dat});
            end
            if (out_ready) begin
                held_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h last=%0d, expected none", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {7'd0, out_data, out_last}, {7'd0, e.dat, e.last});
                end
            end else begin
                held_vld = 1'b1;
                held_dat = out_data;
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    task automatic encrypt_frame(input string name);
        push(8'h5B, 1'b0); push(8'h58, 1'b0); push(8'h59, 1'b0); push(8'h5E, 1'b0); push(8'hFB, 1'b1);
        send(8'h01, 8'h5A, 1'b1);
        send(8'h02, 8'h5A, 1'b1);
        send(8'h03, 8'h5A, 1'b1);
        send(8'h04, 8'h5A, 1'b1);
        check({name, "_latency_out_valid"}, {15'd0, out_valid}, 16'd1);
        drain(name);
        check({name, "_valid_key"}, {15'd0, valid_key}, 16'd1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_out_data", {8'd0, out_data}, 16'd0);
        check("reset_out_last", {15'd0, out_last}, 16'd0);
        check("reset_valid_key", {15'd0, valid_key}, 16'd0);
`ifdef MTE_ERR_CNT_EN
        check("reset_err_count", err_count, 16'd0);
`endif
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Encrypt vector
        encrypt_frame("enc");

        // Decrypt round trip
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b1);
        send(8'h5B, 8'h5A, 1'b0);
        send(8'h58, 8'h5A, 1'b0);
        send(8'h59, 8'h5A, 1'b0);
        send(8'h5E, 8'h5A, 1'b0);
        send(8'hFB, 8'h5A, 1'b0);
        check("dec_check_out_valid", {15'd0, out_valid}, 16'd0);
        check("dec_check_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clock);
        #1;
        check("dec_latency_out_valid", {15'd0, out_valid}, 16'd1);
        drain("dec");
        check("dec_valid_key", {15'd0, valid_key}, 16'd1);

        // Tampered MAC word
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b1);
        send(8'h5B, 8'h5A, 1'b0);
        send(8'h58, 8'h5A, 1'b0);
        send(8'h59, 8'h5A, 1'b0);
        send(8'h5E, 8'h5A, 1'b0);
`ifdef MTE_ERR_CNT_EN
        check("tamper_err_count_before", err_count, 16'd0);
`endif
        send(8'hFA, 8'h5A, 1'b0);
        drain("tamper");
        check("tamper_valid_key", {15'd0, valid_key}, 16'd0);
`ifdef MTE_ERR_CNT_EN
        check("tamper_err_count_after", err_count, 16'd1);
`endif

        // Output backpressure
        stall_mode = 1'b1;
        push(8'h5B, 1'b0); push(8'h58, 1'b0); push(8'h59, 1'b0); push(8'h5E, 1'b0); push(8'hFB, 1'b1);
        send(8'h01, 8'h5A, 1'b1);
        send(8'h02, 8'h5A, 1'b1);
        send(8'h03, 8'h5A, 1'b1);
        send(8'h04, 8'h5A, 1'b1);
        drain("bp");
        stall_mode = 1'b0;
        check("bp_valid_key", {15'd0, valid_key}, 16'd1);

        // Reset mid-frame
        send(8'h01, 8'h5A, 1'b1);
        send(8'h02, 8'h5A, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", {8'd0, out_data}, 16'd0);
        check("rst_out_last", {15'd0, out_last}, 16'd0);
        check("rst_valid_key", {15'd0, valid_key}, 16'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        encrypt_frame("post_rst");

        // Back-to-back: decrypt frame with key/sel changed after the first word
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b1);
        send(8'h5B, 8'h5A, 1'b0);
        check("b2b_valid_key_cleared", {15'd0, valid_key}, 16'd0);
        send(8'h58, 8'h33, 1'b1);
        send(8'h59, 8'h33, 1'b1);
        send(8'h5E, 8'h33, 1'b1);
        send(8'hFB, 8'h33, 1'b1);
        check("b2b_check_valid_key", {15'd0, valid_key}, 16'd0);
        @(posedge clock);
        #1;
        check("b2b_after_check_valid_key", {15'd0, valid_key}, 16'd1);
        drain("b2b");
`ifdef MTE_ERR_CNT_EN
        check("b2b_err_count", err_count, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
